regfile_mp: RTL and testbench

Parametrised multi-port general-purpose register file for the pipelined CPU core. It replaces the fixed 32x32, two-read/one-write register file in the ID/WB stages:
- configurable data width, depth and read-port count;
- second write port for late results (load, mult/div);
- per-register pending scoreboard so the hazard unit can stall on outstanding late writes;
- optional same-cycle write-to-read bypass.

---
 rtl/regfile_mp.sv | 121 ++++++++++++
 tb/tb_regfile_mp.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with two write ports and a
// per-register pending scoreboard for outstanding late (port B) writes.
//
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// (and same-cycle wb pending clears) to the read ports.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ena                      block enable (low: reads 0, updates ignored)
//   wa_en/wa_addr/wa_data    write port A (normal writeback, higher priority)
//   wb_en/wb_addr/wb_data    write port B (late writeback, clears pending)
//   pend_set/pend_addr       mark a register as awaiting a port-B write
//   rd_addr                  RD_PORTS packed read addresses
//   rd_data                  RD_PORTS packed read data (combinational)
//   rd_busy                  per-port pending flag (combinational)
//   sb_err                   sticky scoreboard protocol error (registered)
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned RD_PORTS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ena,
    input  logic                         wa_en,
    input  logic [ADDR_W-1:0]            wa_addr,
    input  logic [DATA_W-1:0]            wa_data,
    input  logic                         wb_en,
    input  logic [ADDR_W-1:0]            wb_addr,
    input  logic [DATA_W-1:0]            wb_data,
    input  logic                         pend_set,
    input  logic [ADDR_W-1:0]            pend_addr,
    input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
    output logic [RD_PORTS*DATA_W-1:0]   rd_data,
    output logic [RD_PORTS-1:0]          rd_busy,
    output logic                         sb_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic              sb_err_q, sb_err_d;

    // Address 0 is hard-wired: every write/pend qualifier excludes it
    logic wa_act_c, wb_act_c, ps_act_c;
    assign wa_act_c = ena & wa_en    & (wa_addr   != '0);
    assign wb_act_c = ena & wb_en    & (wb_addr   != '0);
    assign ps_act_c = ena & pend_set & (pend_addr != '0);

    // Next-state: port B first so port A overrides it on a same-address collision,
    // and pend_set last so a new producer wins over a same-cycle wb clear
    always_comb begin
        regs_d   = regs_q;
        pend_d   = pend_q;
        sb_err_d = sb_err_q;
        if (wb_act_c) begin
            regs_d[wb_addr] = wb_data;
            pend_d[wb_addr] = 1'b0;
            if (!pend_q[wb_addr]) begin
                sb_err_d = 1'b1;
            end
        end
        if (wa_act_c) begin
            regs_d[wa_addr] = wa_data;
        end
        if (ps_act_c) begin
            if (pend_q[pend_addr] && !(wb_act_c && (wb_addr == pend_addr))) begin
                sb_err_d = 1'b1;
            end
            pend_d[pend_addr] = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q   <= '{default: '0};
            pend_q   <= '0;
            sb_err_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            pend_q   <= pend_d;
            sb_err_q <= sb_err_d;
        end
    end

    assign sb_err = sb_err_q;

    // Unpack read addresses per port
    logic [ADDR_W-1:0] rd_a [RD_PORTS];
    for (genvar g = 0; g < RD_PORTS; g++) begin : g_rd_addr
        assign rd_a[g] = rd_addr[g*ADDR_W +: ADDR_W];
    end

    // Combinational read ports
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned i = 0; i < RD_PORTS; i++) begin
            if (ena && (rd_a[i] != '0)) begin
                rd_data[i*DATA_W +: DATA_W] = regs_q[rd_a[i]];
                rd_busy[i]                  = pend_q[rd_a[i]];
`ifdef REGFILE_BYPASS_EN
                if (wa_act_c && (wa_addr == rd_a[i])) begin
                    rd_data[i*DATA_W +: DATA_W] = wa_data;
                end else if (wb_act_c && (wb_addr == rd_a[i])) begin
                    rd_data[i*DATA_W +: DATA_W] = wb_data;
                end
                // An incoming wb retires the pending bit unless re-marked this cycle
                if (wb_act_c && (wb_addr == rd_a[i]) &&
                    !(ps_act_c && (pend_addr == rd_a[i]))) begin
                    rd_busy[i] = 1'b0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed testbench for regfile_mp (default parameters, two read ports).
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        wa_en;
    logic [4:0]  wa_addr;
    logic [31:0] wa_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        pend_set;
    logic [4:0]  pend_addr;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        sb_err;

    int checks;
    int errors;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .RD_PORTS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .wa_en     (wa_en),
        .wa_addr   (wa_addr),
        .wa_data   (wa_data),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .pend_set  (pend_set),
        .pend_addr (pend_addr),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .sb_err    (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs then change 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wa_en    = 1'b0;
        wb_en    = 1'b0;
        pend_set = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; ena = 1'b1;
        wa_en = 1'b0; wa_addr = '0; wa_data = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        pend_set = 1'b0; pend_addr = '0;
        rd_addr = {5'd31, 5'd5};

        // Reset state
        step();
        chk("reset_rd_data", rd_data, 64'h0);
        chk("reset_rd_busy", 64'(rd_busy), 64'h0);
        chk("reset_sb_err", 64'(sb_err), 64'h0);

        // Port A write, read back on both ports
        rst = 1'b0;
        wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEADBEEF;
        rd_addr = {5'd5, 5'd5};
        step();
        idle();
        #1;
        chk("wa_r5_both_ports", rd_data, {32'hDEADBEEF, 32'hDEADBEEF});

        // r0 protection
        wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFFFFFF;
        pend_set = 1'b1; pend_addr = 5'd0;
        rd_addr = {5'd0, 5'd0};
        #1;
        chk("r0_read_during_write", rd_data, 64'h0);
        step();
        idle();
        #1;
        chk("r0_rd_data", rd_data, 64'h0);
        chk("r0_rd_busy", 64'(rd_busy), 64'h0);
        chk("r0_sb_err", 64'(sb_err), 64'h0);

        // Port collision on r7 with pend[7] set beforehand
        pend_set = 1'b1; pend_addr = 5'd7;
        rd_addr = {5'd7, 5'd7};
        step();
        idle();
        #1;
        chk("r7_pending", 64'(rd_busy), 64'h3);
        wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h11111111;
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h22222222;
        step();
        idle();
        #1;
        chk("collision_data", rd_data, {32'h11111111, 32'h11111111});
        chk("collision_busy", 64'(rd_busy), 64'h0);
        chk("collision_sb_err", 64'(sb_err), 64'h0);

        // Scoreboard flow on r9 (port 1 reads r9, port 0 reads r5)
        pend_set = 1'b1; pend_addr = 5'd9;
        rd_addr = {5'd9, 5'd5};
        step();
        idle();
        #1;
        chk("r9_busy_set", 64'(rd_busy), 64'h2);
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h00001234;
        step();
        idle();
        #1;
        chk("r9_wb_data", rd_data, {32'h00001234, 32'hDEADBEEF});
        chk("r9_busy_clear", 64'(rd_busy), 64'h0);
        chk("r9_sb_err", 64'(sb_err), 64'h0);

        // pend_set and wb to the same register: data written, bit stays set, no error
        pend_set = 1'b1; pend_addr = 5'd12;
        rd_addr = {5'd12, 5'd12};
        step();
        idle();
        pend_set = 1'b1; pend_addr = 5'd12;
        wb_en = 1'b1; wb_addr = 5'd12; wb_data = 32'h000000AB;
        #1;
        chk("r12_busy_with_reset_producer", 64'(rd_busy), 64'h3);
        step();
        idle();
        #1;
        chk("r12_data", rd_data, {32'h000000AB, 32'h000000AB});
        chk("r12_still_busy", 64'(rd_busy), 64'h3);
        chk("r12_sb_err", 64'(sb_err), 64'h0);
        // Plain wb retires it; combinational busy depends on bypass
        wb_en = 1'b1; wb_addr = 5'd12; wb_data = 32'h000000CD;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("r12_busy_wb_cycle", 64'(rd_busy), 64'h0);
`else
        chk("r12_busy_wb_cycle", 64'(rd_busy), 64'h3);
`endif
        step();
        idle();
        #1;
        chk("r12_busy_after_wb", 64'(rd_busy), 64'h0);

        // Same-cycle write-to-read
        wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h0000CAFE;
        rd_addr = {5'd3, 5'd3};
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_before_edge", rd_data, {32'h0000CAFE, 32'h0000CAFE});
`else
        chk("bypass_before_edge", rd_data, 64'h0);
`endif
        step();
        idle();
        #1;
        chk("r3_after_edge", rd_data, {32'h0000CAFE, 32'h0000CAFE});

        // ena=0: reads give 0, write ignored
        ena = 1'b0;
        wa_en = 1'b1; wa_addr = 5'd4; wa_data = 32'h00000077;
        pend_set = 1'b1; pend_addr = 5'd4;
        rd_addr = {5'd4, 5'd3};
        #1;
        chk("ena0_rd_data", rd_data, 64'h0);
        step();
        idle();
        ena = 1'b1;
        #1;
        chk("ena0_write_dropped", rd_data, {32'h0, 32'h0000CAFE});
        chk("ena0_pend_dropped", 64'(rd_busy), 64'h0);

        // wb to a non-pending register: sticky error
        wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'h00000010;
        step();
        idle();
        #1;
        chk("sb_err_set", 64'(sb_err), 64'h1);
        step();
        step();
        chk("sb_err_sticky", 64'(sb_err), 64'h1);

        // Reset alongside a write: write discarded, state cleared
        rst = 1'b1;
        wa_en = 1'b1; wa_addr = 5'd4; wa_data = 32'h00000055;
        rd_addr = {5'd4, 5'd5};
        step();
        rst = 1'b0;
        idle();
        #1;
        chk("rst_write_dropped", rd_data, 64'h0);
        chk("rst_sb_err_clear", 64'(sb_err), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
